// File: rtl/sample_frame_buffer.sv
// Ping-pong frame collector feeding the FFT stage: fills one bank while the FFT reads the other.
// Optional build macro DROP_COUNT_EN adds a saturating drop_count_o output.
module sample_frame_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_i,
    input  logic              sample_valid_i,
    input  logic [ADDR_W-1:0] read_input_buffer_address_i,
    input  logic              fft_done_i,
    output logic [DATA_W-1:0] data_o,
    output logic              start_o,
    output logic              busy_o,
`ifdef DROP_COUNT_EN
    output logic [15:0]       drop_count_o,
`endif
    output logic              drop_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic                busy_q, busy_d;
    logic                start_q, start_d;
    logic                drop_q, drop_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_en;

    logic [DATA_W-1:0]   bank0_mem [DEPTH];
    logic [DATA_W-1:0]   bank1_mem [DEPTH];

    // Frame sequencing: accept, complete, swap or stall until the FFT releases its bank
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        wr_ptr_d  = wr_ptr_q;
        busy_d    = busy_q;
        start_d   = 1'b0;
        drop_d    = 1'b0;
        wr_en     = 1'b0;

        if (fft_done_i) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                if (sample_valid_i) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (wr_ptr_q == {ADDR_W{1'b1}}) begin
                        if (!busy_q || fft_done_i) begin
                            wr_bank_d = ~wr_bank_q;
                            start_d   = 1'b1;
                            busy_d    = 1'b1;
                        end else begin
                            state_d = FULL;
                        end
                    end
                end
            end
            FULL: begin
                drop_d = sample_valid_i;
                if (fft_done_i) begin
                    wr_bank_d = ~wr_bank_q;
                    start_d   = 1'b1;
                    busy_d    = 1'b1;
                    wr_ptr_d  = '0;
                    state_d   = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Frozen bank is always the one not being written
    always_comb begin
        data_d = wr_bank_q ? bank0_mem[read_input_buffer_address_i]
                           : bank1_mem[read_input_buffer_address_i];
    end

    always_ff @(posedge clk) begin
        if (wr_en && !wr_bank_q) begin
            bank0_mem[wr_ptr_q] <= sample_i;
        end
        if (wr_en && wr_bank_q) begin
            bank1_mem[wr_ptr_q] <= sample_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FILL;
            wr_bank_q <= 1'b0;
            wr_ptr_q  <= '0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            drop_q    <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            wr_ptr_q  <= wr_ptr_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            drop_q    <= drop_d;
            data_q    <= data_d;
        end
    end

    assign data_o  = data_q;
    assign start_o = start_q;
    assign busy_o  = busy_q;
    assign drop_o  = drop_q;

`ifdef DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Restarts with each new frame; a drop on the swap cycle is the first of the new tally
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (start_d) begin
            drop_cnt_d = 16'(drop_d);
        end else if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_sample_frame_buffer.sv
// Randomized bench for sample_frame_buffer against a frame-level reference model.
module tb_sample_frame_buffer;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned N      = 1024;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] sample_i;
    logic              sample_valid_i;
    logic [ADDR_W-1:0] read_input_buffer_address_i;
    logic              fft_done_i;
    logic [DATA_W-1:0] data_o;
    logic              start_o;
    logic              busy_o;
    logic              drop_o;
`ifdef DROP_COUNT_EN
    logic [15:0]       drop_count_o;
`endif

    sample_frame_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk                         (clk),
        .rst_n                       (rst_n),
        .sample_i                    (sample_i),
        .sample_valid_i              (sample_valid_i),
        .read_input_buffer_address_i (read_input_buffer_address_i),
        .fft_done_i                  (fft_done_i),
        .data_o                      (data_o),
        .start_o                     (start_o),
        .busy_o                      (busy_o),
`ifdef DROP_COUNT_EN
        .drop_count_o                (drop_count_o),
`endif
        .drop_o                      (drop_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the frame being collected, the frozen frame, FFT ownership
    logic [15:0] fill_q[$];
    logic [15:0] frozen[N];
    bit          have_frozen;
    bit          owned;
    bit          exp_start;
    bit          exp_drop;
    bit          exp_data_known;
    logic [15:0] exp_data;
    int          exp_dcount;
    int          start_seen;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        fill_q.delete();
        have_frozen = 1'b0;
        owned       = 1'b0;
        exp_dcount  = 0;
    endtask

    task automatic freeze();
        for (int i = 0; i < int'(N); i++) frozen[i] = fill_q[i];
        fill_q.delete();
        have_frozen = 1'b1;
        owned       = 1'b1;
        exp_start   = 1'b1;
    endtask

    // One clock: apply inputs at the falling edge, advance the model, check after the rising edge
    task automatic cyc(input bit v, input logic [15:0] s, input bit d, input logic [9:0] a);
        sample_valid_i              = v;
        sample_i                    = s;
        fft_done_i                  = d;
        read_input_buffer_address_i = a;

        exp_data_known = have_frozen;
        exp_data       = frozen[a];
        exp_start      = 1'b0;
        exp_drop       = 1'b0;
        if (d) owned = 1'b0;
        if (fill_q.size() == N) begin
            if (v) exp_drop = 1'b1;
            if (d) freeze();
        end else if (v) begin
            fill_q.push_back(s);
            if (fill_q.size() == N && !owned) freeze();
        end
        if (exp_start) exp_dcount = exp_drop ? 1 : 0;
        else if (exp_drop && exp_dcount < 65535) exp_dcount++;

        @(posedge clk);
        #1;
        check_val("start_o", 32'(start_o), 32'(exp_start));
        check_val("drop_o", 32'(drop_o), 32'(exp_drop));
        check_val("busy_o", 32'(busy_o), 32'(owned));
        if (exp_data_known) check_val("data_o", 32'(data_o), 32'(exp_data));
`ifdef DROP_COUNT_EN
        check_val("drop_count_o", 32'(drop_count_o), 32'(exp_dcount));
`endif
        if (start_o === 1'b1) start_seen++;
        @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_start"}, 32'(start_o), 32'd0);
        check_val({tag, "_busy"}, 32'(busy_o), 32'd0);
        check_val({tag, "_drop"}, 32'(drop_o), 32'd0);
        check_val({tag, "_data"}, 32'(data_o), 32'd0);
`ifdef DROP_COUNT_EN
        check_val({tag, "_dcount"}, 32'(drop_count_o), 32'd0);
`endif
    endtask

    initial begin
        int guard;
        int starts_before;
        rst_n                       = 1'b1;
        sample_valid_i              = 1'b0;
        sample_i                    = '0;
        fft_done_i                  = 1'b0;
        read_input_buffer_address_i = '0;
        model_reset();
        start_seen = 0;
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Frame of ramp 0..1023, back-to-back, then read every address
        for (int i = 0; i < int'(N); i++) cyc(1'b1, 16'(i), 1'b0, 10'($urandom));
        check_val("first_start_count", 32'(start_seen), 32'd1);
        for (int k = 0; k < int'(N); k++) cyc(1'b0, 16'($urandom), 1'b0, 10'(k));

        // Fill during FFT ownership -> stall; three dropped samples; release by done
        for (int i = 0; i < int'(N); i++) cyc(1'b1, 16'(5000 + i), 1'b0, 10'($urandom));
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'($urandom), 1'b0, 10'($urandom));
        cyc(1'b0, 16'd0, 1'b1, 10'($urandom));
        for (int k = 0; k < int'(N); k++) cyc(1'b0, 16'd0, 1'b0, 10'(k));

        // Done coincides with the last write of a frame -> direct swap
        for (int i = 0; i < int'(N) - 1; i++) cyc(1'b1, 16'($urandom), 1'b0, 10'($urandom));
        cyc(1'b1, 16'($urandom), 1'b1, 10'($urandom));

        // 1-in-4 duty after releasing the bank
        cyc(1'b0, 16'd0, 1'b1, 10'd0);
        for (int i = 0; i < 4 * int'(N); i++)
            cyc((i % 4) == 0, 16'($urandom), 1'b0, 10'($urandom));
        for (int k = 0; k < int'(N); k++) cyc(1'b0, 16'd0, 1'b0, 10'(k));

        // Done while idle is ignored
        cyc(1'b0, 16'd0, 1'b1, 10'd0);
        starts_before = start_seen;
        cyc(1'b0, 16'd0, 1'b1, 10'd0);
        cyc(1'b0, 16'd0, 1'b0, 10'd0);
        check_val("idle_done_no_start", 32'(start_seen), 32'(starts_before));

        // Random traffic
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom), 16'($urandom), ($urandom_range(63) == 0), 10'($urandom));

        // Reach wr_ptr=500 with the FFT owning a bank, then reset mid-frame
        cyc(1'b0, 16'd0, 1'b1, 10'd0);
        guard = 0;
        while (!(owned && fill_q.size() == 500) && guard < 4000) begin
            cyc(1'b1, 16'($urandom), 1'b0, 10'($urandom));
            guard++;
        end
        check_val("reach_ptr500_timeout", 32'(guard < 4000), 32'd1);
        sample_valid_i = 1'b0;
        fft_done_i     = 1'b0;
        rst_n          = 1'b0;
        #1 check_outputs_zero("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        starts_before = start_seen;
        for (int i = 0; i < int'(N) - 1; i++) cyc(1'b1, 16'($urandom), 1'b0, 10'($urandom));
        check_val("no_start_before_full_frame", 32'(start_seen), 32'(starts_before));
        cyc(1'b1, 16'($urandom), 1'b0, 10'($urandom));
        check_val("start_after_full_frame", 32'(start_seen), 32'(starts_before + 1));
        for (int k = 0; k < 64; k++) cyc(1'b0, 16'd0, 1'b0, 10'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
